// File: rtl/processinho_pkg.sv
// Shared definitions for the processinho control path: opcode map, ALU
// operation codes and the control-state encoding (also decoded by the
// datapath and the HEX debug display).
package processinho_pkg;

  // Opcode map as fetched from ROM
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // ALU operation codes driven on ula_operation
  localparam logic [3:0] ULA_ADD = 4'h0;
  localparam logic [3:0] ULA_SUB = 4'h1;
  localparam logic [3:0] ULA_AND = 4'h2;
  localparam logic [3:0] ULA_OR  = 4'h3;

  // Control-state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_ADVANCE   = 3'd5;
  localparam logic [2:0] ST_HALTED    = 3'd6;

  // True for the four opcodes that use the ALU
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // ALU operation code for an ALU opcode; ADD code for anything else
  function automatic logic [3:0] ula_code(input logic [2:0] op);
    logic [3:0] code;
    code = ULA_ADD;
    case (op)
      OP_SUB:  code = ULA_SUB;
      OP_AND:  code = ULA_AND;
      OP_OR:   code = ULA_OR;
      default: code = ULA_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Up-counter that wraps to zero after LAST. Used both as the program
// counter and as the RAM write pointer.
module pc_counter #(
  parameter int              WIDTH = 3,
  parameter logic [WIDTH-1:0] LAST = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Advance on i_inc, wrapping after LAST
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer for the processinho datapath. Fetches opcodes from
// ROM at the program counter, decodes them and produces the ALU and RAM
// strobes. All strobes are Moore outputs of the state and the latched
// instruction register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for run (level) or step (pulse)
// FETCH     | ROM read at pc_count
// DECODE    | opcode captured into ir
// EXECUTE   | ALU grab / RAM read address for LOAD
// WRITEBACK | ALU result onto bus, RAM write for STORE
// ADVANCE   | pc_increment; loop back to FETCH while run is held
// HALTED    | HALT executed; only reset leaves this state
module control_unit
  import processinho_pkg::*;
#(
  parameter int PC_WIDTH   = 3,
  parameter int PC_LAST    = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic [2:0]            opcode,
  output logic                  rom_enable,
  output logic [PC_WIDTH-1:0]   pc_count,
  output logic                  pc_increment,
  output logic                  grab_ula,
  output logic                  latch_ula,
  output logic [3:0]            ula_operation,
  output logic                  ram_enable,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  halted,
  output logic                  busy
);

  logic [2:0]            r_state;
  logic [2:0]            r_ir;
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic                  w_pc_inc;
  logic                  w_wr_inc;

  assign w_pc_inc = (r_state == ST_ADVANCE);
  assign w_wr_inc = (r_state == ST_WRITEBACK) && (r_ir == OP_STORE);

  pc_counter #(
    .WIDTH (PC_WIDTH),
    .LAST  (PC_WIDTH'(PC_LAST))
  ) u_pc (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_pc_inc),
    .o_count (pc_count)
  );

  // The write pointer wraps over the full RAM address space
  pc_counter #(
    .WIDTH (ADDR_WIDTH),
    .LAST  ({ADDR_WIDTH{1'b1}})
  ) u_wr_ptr (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_wr_inc),
    .o_count (w_wr_ptr)
  );

  // State sequencing and instruction capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ir    <= OP_NOP;
    end else begin
      case (r_state)
        ST_IDLE:      if (run || step) r_state <= ST_FETCH;
        ST_FETCH:     r_state <= ST_DECODE;
        ST_DECODE: begin
          r_ir <= opcode;
          if (opcode == OP_NOP)       r_state <= ST_ADVANCE;
          else if (opcode == OP_HALT) r_state <= ST_HALTED;
          else                        r_state <= ST_EXECUTE;
        end
        ST_EXECUTE:   r_state <= ST_WRITEBACK;
        ST_WRITEBACK: r_state <= ST_ADVANCE;
        ST_ADVANCE:   r_state <= run ? ST_FETCH : ST_IDLE;
        ST_HALTED:    r_state <= ST_HALTED;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore strobe decode from state and ir
  always_comb begin
    rom_enable    = 1'b0;
    pc_increment  = 1'b0;
    grab_ula      = 1'b0;
    latch_ula     = 1'b0;
    ula_operation = ULA_ADD;
    ram_enable    = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    halted        = 1'b0;
    busy          = 1'b0;
    case (r_state)
      ST_FETCH: begin
        rom_enable = 1'b1;
        busy       = 1'b1;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXECUTE: begin
        busy = 1'b1;
        if (is_alu_op(r_ir)) begin
          grab_ula      = 1'b1;
          ula_operation = ula_code(r_ir);
        end else if (r_ir == OP_LOAD) begin
          // LOAD reads back the most recently stored word
          ram_enable = 1'b1;
          ram_addr   = w_wr_ptr - 1'b1;
        end
      end
      ST_WRITEBACK: begin
        busy = 1'b1;
        if (is_alu_op(r_ir)) begin
          latch_ula = 1'b1;
        end else if (r_ir == OP_STORE) begin
          latch_ula  = 1'b1;
          ram_enable = 1'b1;
          ram_we     = 1'b1;
          ram_addr   = w_wr_ptr;
        end
      end
      ST_ADVANCE: begin
        busy         = 1'b1;
        pc_increment = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction sequencer that drives the processor datapath.
- Owns the program counter and drives the ROM address and enable; receives the fetched opcode and decodes it.
- Generates the datapath strobes: grab_ula, latch_ula, ula_operation, pc_increment, and the RAM enable, write and address.
- Replaces the hand-driven control inputs at the processor top level.

Parameters:
PC_WIDTH, 3, program counter width
PC_LAST, 6, last valid ROM address; PC wraps to 0 after it
ADDR_WIDTH, 4, RAM address width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level: execute instructions continuously
step  input  1  one-cycle pulse: execute exactly one instruction from IDLE
opcode  input  3  ROM output, valid the cycle after rom_enable
rom_enable  output  1  ROM read enable
pc_count  output  PC_WIDTH  ROM address (program counter)
pc_increment  output  1  one-cycle pulse when PC advances
grab_ula  output  1  capture ALU result in its buffer
latch_ula  output  1  drive ALU result onto data_bus
ula_operation  output  4  ALU operation code
ram_enable  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
halted  output  1  HALT executed
busy  output  1  state is not IDLE and not HALTED

Behaviour:
- Reset: one clock and reset port as named above; reset is synchronous and active-high.
  - On reset: state=IDLE, pc_count=0, ir=0, wr_ptr=0, all outputs 0.
  - Reset overrides any state, including mid-instruction; an interrupted instruction has no further effect.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, ADVANCE, HALTED.
  - IDLE: go to FETCH if run=1 or step=1. If both are set, run takes precedence.
  - FETCH: rom_enable=1 with pc_count presented; go to DECODE.
  - DECODE: ir <= opcode.
    - NOP: go to ADVANCE.
    - HALT: go to HALTED.
    - Otherwise: go to EXECUTE.
  - EXECUTE:
    - ALU ops: grab_ula=1 and ula_operation=code for exactly 1 cycle.
    - LOAD: ram_enable=1, ram_we=0, ram_addr=wr_ptr-1 (mod 2^ADDR_WIDTH; when wr_ptr=0 this is the all-ones address).
    - STORE: nothing.
    - All cases go to WRITEBACK.
  - WRITEBACK:
    - ALU ops: latch_ula=1 for 1 cycle.
    - STORE: latch_ula=1, ram_enable=1, ram_we=1, ram_addr=wr_ptr; then wr_ptr<=wr_ptr+1, wrapping.
    - LOAD: strobes 0; RAM data is on the bus this cycle.
    - All cases go to ADVANCE.
  - ADVANCE: pc_increment=1 for 1 cycle; pc_count <= (pc_count==PC_LAST) ? 0 : pc_count+1.
    - Go to FETCH if run=1, else IDLE.
    - Deasserting run mid-instruction completes the current instruction before stopping.
  - HALTED: halted=1. Stays here until reset; run and step are ignored.
- Opcode map: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LOAD, 110 STORE, 111 HALT.
- ula_operation codes: ADD 4'h0, SUB 4'h1, AND 4'h2, OR 4'h3. Value is 4'h0 outside EXECUTE.
- Latency:
  - ALU, LOAD, STORE: 5 cycles (FETCH to ADVANCE).
  - NOP: 3 cycles.
  - HALT: 2 cycles, then HALTED.
- Strobes are Moore outputs decoded from state and ir. Each strobe is high only in the stated state, never two cycles in a row for one instruction.
- busy is high in FETCH through ADVANCE.
- pc_count never exceeds PC_LAST, including after reset and after wrap.

Decomposition:
- Shared package processinho_pkg holds:
  - opcode constants OP_NOP through OP_HALT;
  - ULA_ADD, ULA_SUB, ULA_AND, ULA_OR;
  - the control-state enumeration, so the datapath and HEX debug display can decode state.
- One sub-module, pc_counter: a wrap-at-PC_LAST counter with synchronous reset and increment enable, reusable for wr_ptr with the wrap set to 2^ADDR_WIDTH-1.

Test Plan:
- Reset, then run=1 with ROM = NOP×7 -> pc_increment every 3 cycles; pc_count sequence 0..6 then 0; no ALU or RAM strobes.
- ROM[0]=ADD (001), step pulse -> grab_ula high 1 cycle with ula_operation=4'h0 on the 3rd cycle, latch_ula on the 4th, pc_increment on the 5th, then IDLE with pc_count=1.
- STORE, STORE, LOAD from wr_ptr=0 -> writes at ram_addr 0 then 1, each with ram_we=1; LOAD reads ram_addr 1 with ram_we=0; wr_ptr ends at 2. LOAD with wr_ptr=0 -> ram_addr=4'hF.
- ROM[2]=HALT, run=1 -> halted=1 after cycle 2 of that instruction; pc_count stays 2; toggling run or step causes no change until reset.
- Reset asserted during the EXECUTE of SUB -> on the next cycle all strobes are 0, pc_count=0, state=IDLE, and no latch_ula is ever seen.
- run and step both high in IDLE -> continuous execution; run dropped during the EXECUTE of an ALU op -> WRITEBACK and ADVANCE complete, then IDLE.
